// File: rtl/fp32_to_int_serial.sv
// fp32_to_int_serial
//   Converts one IEEE-754 binary32 operand to a signed 32-bit integer,
//   truncating toward zero. The mantissa moves one bit per clock, so a
//   conversion takes |exp-150|+1 cycles from acceptance to result. Only one
//   operand is held at a time.
//
//   Ports
//     clk, rst_n    clock, asynchronous active-low reset
//     in_valid      in_data holds an operand
//     in_ready      block is idle and can take an operand
//     in_data       binary32 {sign, exp[7:0], frac[22:0]}
//     out_valid     result is held and waiting for the consumer
//     out_ready     consumer takes the result
//     out_data      signed integer result
//     out_overflow  |value| >= 2^31 (except exactly -2^31), Inf or NaN
//     out_inexact   nonzero fraction bits were discarded
//
//   SAT_EN=1: overflow/NaN saturate by sign. SAT_EN=0: they return 0x80000000.
module fp32_to_int_serial #(
  parameter bit SAT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_overflow,
  output logic        out_inexact
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_FIX   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]  state;
  logic        sgn;
  logic [31:0] mag;
  logic [4:0]  cnt;
  logic        left;
  logic        ovf;
  logic        inx;

  logic [7:0]  exp_in;
  logic [22:0] frac_in;
  logic [7:0]  rdist;
  logic [7:0]  ldist;

  assign exp_in  = in_data[30:23];
  assign frac_in = in_data[22:0];
  assign rdist   = 8'd150 - exp_in;
  assign ldist   = exp_in - 8'd150;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      sgn          <= 1'b0;
      mag          <= 32'd0;
      cnt          <= 5'd0;
      left         <= 1'b0;
      ovf          <= 1'b0;
      inx          <= 1'b0;
      out_data     <= 32'd0;
      out_overflow <= 1'b0;
      out_inexact  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            sgn  <= in_data[31];
            mag  <= {8'd0, 1'b1, frac_in};
            ovf  <= 1'b0;
            inx  <= 1'b0;
            left <= 1'b0;
            cnt  <= 5'd0;
            if (exp_in == 8'd255) begin
              ovf   <= 1'b1;
              state <= ST_FIX;
            end else if (exp_in == 8'd0) begin
              // denormals flush to zero
              mag   <= 32'd0;
              inx   <= (frac_in != 23'd0);
              state <= ST_FIX;
            end else if (exp_in < 8'd127) begin
              mag   <= 32'd0;
              inx   <= 1'b1;
              state <= ST_FIX;
            end else if (exp_in >= 8'd158) begin
              // -2^31 is representable: negating 0x80000000 yields itself
              if (in_data[31] && exp_in == 8'd158 && frac_in == 23'd0)
                mag <= 32'h8000_0000;
              else
                ovf <= 1'b1;
              state <= ST_FIX;
            end else if (exp_in < 8'd150) begin
              cnt   <= rdist[4:0];
              state <= ST_SHIFT;
            end else if (exp_in == 8'd150) begin
              state <= ST_FIX;
            end else begin
              left  <= 1'b1;
              cnt   <= ldist[4:0];
              state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          if (left) begin
            mag <= mag << 1;
          end else begin
            mag <= mag >> 1;
            inx <= inx | mag[0];
          end
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) state <= ST_FIX;
        end
        ST_FIX: begin
          if (ovf)
            out_data <= SAT_EN ? (sgn ? 32'h8000_0000 : 32'h7FFF_FFFF) : 32'h8000_0000;
          else
            out_data <= sgn ? (~mag + 32'd1) : mag;
          out_overflow <= ovf;
          out_inexact  <= inx;
          state        <= ST_DONE;
        end
        default: begin
          if (out_ready) state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_to_int_serial.sv
// Bench for fp32_to_int_serial: directed table, random vectors against a
// numeric reference model, output hold, and asynchronous reset abort.
// Two instances run in lockstep: saturating (SAT_EN=1) and non-saturating.
module tb_fp32_to_int_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_overflow, out_inexact;
  logic [31:0] out_data;
  logic        in_ready0, out_valid0, out_overflow0, out_inexact0;
  logic [31:0] out_data0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp32_to_int_serial #(.SAT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_overflow(out_overflow), .out_inexact(out_inexact)
  );

  fp32_to_int_serial #(.SAT_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_overflow(out_overflow0), .out_inexact(out_inexact0)
  );

  typedef struct {
    logic [31:0] din;
    logic [31:0] res;
    bit          ovf;
    bit          inx;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: value = {1,frac} * 2^(e-150), truncated, then range-checked
  // as a signed number.
  function automatic void model(input logic [31:0] x, input bit sat,
                                output logic [31:0] res, output bit ovf,
                                output bit inx, output int lat);
    bit     s;
    int     e, sh;
    longint mant, mag, v;
    bit     big;
    s = x[31];
    e = int'(x[30:23]);
    mant = longint'({1'b1, x[22:0]});
    res = 32'd0; ovf = 1'b0; inx = 1'b0; lat = 1; big = 1'b0; mag = 0;
    if (e == 255) begin
      ovf = 1'b1;
    end else if (e == 0) begin
      inx = (x[22:0] != 23'd0);
    end else begin
      sh = e - 150;
      if (sh >= 0) begin
        if (sh > 40) big = 1'b1;
        else mag = mant << sh;
      end else if (-sh >= 32) begin
        mag = 0;
        inx = 1'b1;
      end else begin
        mag = mant >> (-sh);
        inx = ((mag << (-sh)) != mant);
      end
      if (e >= 127 && e <= 157 && e != 150) lat = (sh < 0 ? -sh : sh) + 1;
      v = s ? -mag : mag;
      if (big || v > 64'sd2147483647 || v < -64'sd2147483648) ovf = 1'b1;
      else res = v[31:0];
    end
    if (ovf) begin
      inx = 1'b0;
      res = sat ? (s ? 32'h8000_0000 : 32'h7FFF_FFFF) : 32'h8000_0000;
    end
  endfunction

  // Accept one operand, wait for the result, check it, then hand it off.
  task automatic run_one(input string nm, input logic [31:0] x,
                         input logic [31:0] res, input bit ovf, input bit inx,
                         input int lat);
    int n;
    @(negedge clk);
    chk({nm, " in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = x;
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_data = 32'hDEAD_BEEF;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    if (!out_valid) begin
      errors++; checks++;
      $display("FAIL %s timeout: out_valid never rose", nm);
    end
    chk({nm, " latency"}, 32'(n), 32'(lat));
    chk({nm, " data"}, out_data, res);
    chk({nm, " ovf"}, {31'd0, out_overflow}, {31'd0, ovf});
    chk({nm, " inx"}, {31'd0, out_inexact}, {31'd0, inx});
    chk({nm, " data nosat"}, out_data0, ovf ? 32'h8000_0000 : res);
    chk({nm, " ovf nosat"}, {31'd0, out_overflow0}, {31'd0, ovf});
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({nm, " back to idle"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  vec_t tbl[12];

  function automatic vec_t mk(input logic [31:0] d, input logic [31:0] r,
                              input bit o, input bit i, input int l);
    vec_t t;
    t.din = d; t.res = r; t.ovf = o; t.inx = i; t.lat = l;
    return t;
  endfunction

  initial begin
    logic [31:0] x, r, held;
    bit o, i;
    int l, n;

    tbl[0]  = mk(32'h4049_0FDB, 32'h0000_0003, 0, 1, 23);
    tbl[1]  = mk(32'hC2F6_0000, 32'hFFFF_FF85, 0, 0, 18);
    tbl[2]  = mk(32'h4E80_0001, 32'h4000_0080, 0, 0, 8);
    tbl[3]  = mk(32'h4F00_0000, 32'h7FFF_FFFF, 1, 0, 1);
    tbl[4]  = mk(32'hCF00_0000, 32'h8000_0000, 0, 0, 1);
    tbl[5]  = mk(32'h7FC0_0000, 32'h7FFF_FFFF, 1, 0, 1);
    tbl[6]  = mk(32'h0000_0000, 32'h0000_0000, 0, 0, 1);
    tbl[7]  = mk(32'h3F00_0000, 32'h0000_0000, 0, 1, 1);
    tbl[8]  = mk(32'h8000_0001, 32'h0000_0000, 0, 1, 1);
    tbl[9]  = mk(32'h4B00_0000, 32'h0080_0000, 0, 0, 1);
    tbl[10] = mk(32'hBF80_0000, 32'hFFFF_FFFF, 0, 0, 24);
    tbl[11] = mk(32'hCF00_0001, 32'h8000_0000, 1, 0, 1);

    // reset state
    #12;
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst out_data", out_data, 32'd0);
    chk("rst flags", {30'd0, out_overflow, out_inexact}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst in_ready", {31'd0, in_ready}, 32'd1);

    // in_valid drop without handshake while idle is harmless; out_ready ignored
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle out_ready ignored", {30'd0, out_valid, in_ready}, 32'd1);

    foreach (tbl[k])
      run_one($sformatf("vec%0d", k), tbl[k].din, tbl[k].res, tbl[k].ovf,
              tbl[k].inx, tbl[k].lat);

    // random operands, exponent biased toward the interesting window
    for (int k = 0; k < 150; k++) begin
      x = $urandom;
      if ($urandom_range(0, 3) != 0) x[30:23] = 8'($urandom_range(120, 160));
      model(x, 1'b1, r, o, i, l);
      run_one($sformatf("rnd%0d_%h", k, x), x, r, o, i, l);
    end

    // hold in DONE with out_ready low; new operands must be ignored
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 32'hC2F6_0000;
    @(posedge clk);
    #1 in_data = 32'h4049_0FDB;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    held = out_data;
    chk("hold first data", held, 32'hFFFF_FF85);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold c%0d data", c), out_data, 32'hFFFF_FF85);
      chk($sformatf("hold c%0d hs", c),
          {29'd0, out_valid, in_ready, out_overflow | out_inexact}, 32'd4);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("after hold idle", {30'd0, out_valid, in_ready}, 32'd1);
    @(posedge clk);
    #1 chk("data kept in idle", out_data, 32'hFFFF_FF85);

    // reset mid-SHIFT aborts without a clock edge
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 32'h4049_0FDB;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort out_data", out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort in_ready", {31'd0, in_ready}, 32'd1);
    run_one("post-abort", 32'h4049_0FDB, 32'h0000_0003, 0, 1, 23);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
